// File: rtl/apb_regspace_bridge.sv
// -----------------------------------------------------------------------------
// apb_regspace_bridge
//
// APB4 completer that converts each APB transfer into one handshake on the
// read-request / read-acknowledge channels (reads) or on the write-request
// channel (writes) of a generated register space.
//
// Beyond a plain bridge it provides:
//   - configurable address / data widths, byte strobes passed downstream
//   - address-window and alignment decode, optional privileged-write check
//   - a per-handshake downstream timeout that completes with PSLVERR
//   - draining of a read response that arrives after its read timed out
//
// Parameters:
//   ADDR_W   APB and downstream address width
//   DATA_W   data width (8, 16, 32 or 64)
//   ADDR_LO  lowest decoded byte address (inclusive)
//   ADDR_HI  highest decoded byte address (inclusive)
//   TIMEOUT  wait cycles allowed per downstream handshake, 0 = no timeout
//   PRIV_WR  1 = writes with p_prot[0]=0 are rejected
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   p_addr/p_prot/p_sel/p_enable/p_write/p_wdata/p_strb   APB request
//   p_ready/p_rdata/p_slverr     APB response (registered, one-cycle pulse)
//   rreq_addr/rreq_vld/rreq_rdy  read request channel
//   rack_data/rack_vld/rack_rdy  read acknowledge channel
//   wreq_addr/wreq_data/wreq_strb/wreq_vld/wreq_rdy  write request channel
//
// All outputs are registers updated together with the state, so every
// downstream output is a pure function of the current state (Moore).
// -----------------------------------------------------------------------------
module apb_regspace_bridge #(
    parameter int unsigned ADDR_W  = 32'd16,
    parameter int unsigned DATA_W  = 32'd32,
    parameter int unsigned ADDR_LO = 32'h0000_0000,
    parameter int unsigned ADDR_HI = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT = 32'd16,
    parameter int unsigned PRIV_WR = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // APB completer
    input  logic [ADDR_W-1:0]     p_addr,
    input  logic [2:0]            p_prot,
    input  logic                  p_sel,
    input  logic                  p_enable,
    input  logic                  p_write,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [DATA_W/8-1:0]   p_strb,
    output logic                  p_ready,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_slverr,
    // read request
    output logic [ADDR_W-1:0]     rreq_addr,
    output logic                  rreq_vld,
    input  logic                  rreq_rdy,
    // read acknowledge
    input  logic [DATA_W-1:0]     rack_data,
    input  logic                  rack_vld,
    output logic                  rack_rdy,
    // write request
    output logic [ADDR_W-1:0]     wreq_addr,
    output logic [DATA_W-1:0]     wreq_data,
    output logic [DATA_W/8-1:0]   wreq_strb,
    output logic                  wreq_vld,
    input  logic                  wreq_rdy
);

    localparam int unsigned STRB_W = DATA_W / 32'd8;

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    // Address bits below the data-word size must be zero.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 32'd1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RREQ = 3'd1,
        RACK = 3'd2,
        WREQ = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                drain_r;
    logic                p_ready_r;
    logic                p_slverr_r;
    logic [DATA_W-1:0]   p_rdata_r;
    logic [ADDR_W-1:0]   rreq_addr_r;
    logic                rreq_vld_r;
    logic                rack_rdy_r;
    logic [ADDR_W-1:0]   wreq_addr_r;
    logic [DATA_W-1:0]   wreq_data_r;
    logic [STRB_W-1:0]   wreq_strb_r;
    logic                wreq_vld_r;

    logic                setup_s;
    logic                rack_hs_s;
    logic                drain_next_s;
    logic                timeout_s;
    logic                decode_err_s;
    logic                unused_prot_s;

    // Returns 1 when a setup-phase request must be answered with PSLVERR
    // without touching the register space.
    function automatic logic decode_err(
        input logic [ADDR_W-1:0] addr,
        input logic              wr,
        input logic              prot0
    );
        logic out_of_window;
        logic misaligned;
        logic priv_fail;
        // Compare in 64 bits so window edges equal to the address range
        // limits do not degenerate into constant comparisons.
        out_of_window = (64'(addr) < 64'(ADDR_LO)) || (64'(addr) > 64'(ADDR_HI));
        misaligned    = |(addr & ALIGN_MASK);
        priv_fail     = (PRIV_WR != 32'd0) && wr && !prot0;
        return out_of_window || misaligned || priv_fail;
    endfunction

    // Only the privileged bit of p_prot carries meaning here.
    assign unused_prot_s = ^p_prot[2:1];

    assign setup_s      = p_sel & ~p_enable;
    assign rack_hs_s    = rack_rdy_r & rack_vld;
    // A handshake seen while draining consumes the stale response.
    assign drain_next_s = drain_r & ~rack_hs_s;
    assign timeout_s    = (TIMEOUT != 32'd0) && (cnt_r == TO_LAST);
    assign decode_err_s = decode_err(p_addr, p_write, p_prot[0]);

    // Transfer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            drain_r     <= 1'b0;
            p_ready_r   <= 1'b0;
            p_slverr_r  <= 1'b0;
            p_rdata_r   <= '0;
            rreq_addr_r <= '0;
            rreq_vld_r  <= 1'b0;
            rack_rdy_r  <= 1'b0;
            wreq_addr_r <= '0;
            wreq_data_r <= '0;
            wreq_strb_r <= '0;
            wreq_vld_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    drain_r <= drain_next_s;
                    if (setup_s) begin
                        rreq_addr_r <= p_addr;
                        wreq_addr_r <= p_addr;
                        wreq_data_r <= p_wdata;
                        wreq_strb_r <= p_strb;
                        cnt_r       <= '0;
                        if (decode_err_s) begin
                            state_r    <= DONE;
                            p_ready_r  <= 1'b1;
                            p_slverr_r <= 1'b1;
                            rack_rdy_r <= 1'b0;
                        end else if (p_write) begin
                            state_r    <= WREQ;
                            wreq_vld_r <= 1'b1;
                            rack_rdy_r <= drain_next_s;
                        end else begin
                            state_r    <= RREQ;
                            rreq_vld_r <= 1'b1;
                            rack_rdy_r <= drain_next_s;
                        end
                    end else begin
                        rack_rdy_r <= drain_next_s;
                    end
                end

                RREQ: begin
                    drain_r <= drain_next_s;
                    if (rreq_rdy) begin
                        state_r    <= RACK;
                        rreq_vld_r <= 1'b0;
                        rack_rdy_r <= 1'b1;
                        cnt_r      <= '0;
                    end else if (timeout_s) begin
                        // Request stays outstanding downstream; no drain.
                        state_r    <= DONE;
                        rreq_vld_r <= 1'b0;
                        rack_rdy_r <= 1'b0;
                        p_ready_r  <= 1'b1;
                        p_slverr_r <= 1'b1;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                        rack_rdy_r <= drain_next_s;
                    end
                end

                RACK: begin
                    if (rack_vld) begin
                        if (drain_r) begin
                            // Stale response from a timed-out read: drop it
                            // and keep waiting for this read's own data.
                            drain_r <= 1'b0;
                            cnt_r   <= '0;
                        end else begin
                            state_r    <= DONE;
                            rack_rdy_r <= 1'b0;
                            p_ready_r  <= 1'b1;
                            p_rdata_r  <= rack_data;
                        end
                    end else if (timeout_s) begin
                        // The response may still arrive; swallow it later.
                        state_r    <= DONE;
                        rack_rdy_r <= 1'b0;
                        p_ready_r  <= 1'b1;
                        p_slverr_r <= 1'b1;
                        drain_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                WREQ: begin
                    drain_r <= drain_next_s;
                    if (wreq_rdy) begin
                        state_r    <= DONE;
                        wreq_vld_r <= 1'b0;
                        rack_rdy_r <= 1'b0;
                        p_ready_r  <= 1'b1;
                    end else if (timeout_s) begin
                        state_r    <= DONE;
                        wreq_vld_r <= 1'b0;
                        rack_rdy_r <= 1'b0;
                        p_ready_r  <= 1'b1;
                        p_slverr_r <= 1'b1;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                        rack_rdy_r <= drain_next_s;
                    end
                end

                DONE: begin
                    // rack_rdy is low here, so drain cannot change.
                    state_r    <= IDLE;
                    p_ready_r  <= 1'b0;
                    p_slverr_r <= 1'b0;
                    p_rdata_r  <= '0;
                    rack_rdy_r <= drain_r;
                end

                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= '0;
                    drain_r    <= 1'b0;
                    p_ready_r  <= 1'b0;
                    p_slverr_r <= 1'b0;
                    p_rdata_r  <= '0;
                    rreq_vld_r <= 1'b0;
                    rack_rdy_r <= 1'b0;
                    wreq_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign p_ready   = p_ready_r;
    assign p_slverr  = p_slverr_r;
    assign p_rdata   = p_rdata_r;
    assign rreq_addr = rreq_addr_r;
    assign rreq_vld  = rreq_vld_r;
    assign rack_rdy  = rack_rdy_r;
    assign wreq_addr = wreq_addr_r;
    assign wreq_data = wreq_data_r;
    assign wreq_strb = wreq_strb_r;
    assign wreq_vld  = wreq_vld_r;

endmodule

// File: tb/tb_apb_regspace_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_regspace_bridge
//
// Directed bench for apb_regspace_bridge configured with a 4 KiB window,
// privileged writes and a 4-cycle timeout. Inputs change and outputs are
// checked 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_regspace_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] p_addr = 16'h0000;
    logic [2:0]  p_prot = 3'b000;
    logic        p_sel = 1'b0;
    logic        p_enable = 1'b0;
    logic        p_write = 1'b0;
    logic [31:0] p_wdata = 32'h0;
    logic [3:0]  p_strb = 4'h0;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        p_slverr;
    logic [15:0] rreq_addr;
    logic        rreq_vld;
    logic        rreq_rdy = 1'b0;
    logic [31:0] rack_data = 32'h0;
    logic        rack_vld = 1'b0;
    logic        rack_rdy;
    logic [15:0] wreq_addr;
    logic [31:0] wreq_data;
    logic [3:0]  wreq_strb;
    logic        wreq_vld;
    logic        wreq_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_regspace_bridge #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .ADDR_LO (32'h0000_0000),
        .ADDR_HI (32'h0000_0FFF),
        .TIMEOUT (4),
        .PRIV_WR (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_addr    (p_addr),
        .p_prot    (p_prot),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_wdata   (p_wdata),
        .p_strb    (p_strb),
        .p_ready   (p_ready),
        .p_rdata   (p_rdata),
        .p_slverr  (p_slverr),
        .rreq_addr (rreq_addr),
        .rreq_vld  (rreq_vld),
        .rreq_rdy  (rreq_rdy),
        .rack_data (rack_data),
        .rack_vld  (rack_vld),
        .rack_rdy  (rack_rdy),
        .wreq_addr (wreq_addr),
        .wreq_data (wreq_data),
        .wreq_strb (wreq_strb),
        .wreq_vld  (wreq_vld),
        .wreq_rdy  (wreq_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a setup phase, pass edge E0, and enter the access phase.
    task automatic apb_setup(input logic [15:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] pr);
        p_sel    = 1'b1;
        p_enable = 1'b0;
        p_addr   = a;
        p_write  = w;
        p_wdata  = d;
        p_strb   = s;
        p_prot   = pr;
        tick();
        p_enable = 1'b1;
    endtask

    task automatic apb_release();
        p_sel    = 1'b0;
        p_enable = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        check("rst_p_ready", p_ready, 1'b0);
        check("rst_p_slverr", p_slverr, 1'b0);
        check("rst_p_rdata", p_rdata, 32'h0);
        check("rst_rreq_vld", rreq_vld, 1'b0);
        check("rst_rack_rdy", rack_rdy, 1'b0);
        check("rst_wreq_vld", wreq_vld, 1'b0);
        check("rst_wreq_addr", wreq_addr, 16'h0);
        check("rst_wreq_data", wreq_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- zero-wait read 0x0010 ----------------
        rreq_rdy  = 1'b1;
        rack_vld  = 1'b1;
        rack_data = 32'hDEAD_BEEF;
        apb_setup(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000);
        check("rd_c1_rreq_vld", rreq_vld, 1'b1);
        check("rd_c1_rreq_addr", rreq_addr, 16'h0010);
        check("rd_c1_p_ready", p_ready, 1'b0);
        tick();
        check("rd_c2_rack_rdy", rack_rdy, 1'b1);
        check("rd_c2_rreq_vld", rreq_vld, 1'b0);
        check("rd_c2_p_ready", p_ready, 1'b0);
        tick();
        check("rd_c3_p_ready", p_ready, 1'b1);
        check("rd_c3_p_rdata", p_rdata, 32'hDEAD_BEEF);
        check("rd_c3_p_slverr", p_slverr, 1'b0);
        check("rd_c3_rack_rdy", rack_rdy, 1'b0);
        tick();
        apb_release();
        rreq_rdy = 1'b0;
        rack_vld = 1'b0;
        check("rd_c4_p_ready", p_ready, 1'b0);
        check("rd_c4_p_rdata", p_rdata, 32'h0);

        // ---------------- write 0x0020 with 2 stall cycles ----------------
        apb_setup(16'h0020, 1'b1, 32'h1234_5678, 4'b0101, 3'b001);
        check("wr_c1_wreq_vld", wreq_vld, 1'b1);
        check("wr_c1_wreq_addr", wreq_addr, 16'h0020);
        check("wr_c1_wreq_data", wreq_data, 32'h1234_5678);
        check("wr_c1_wreq_strb", wreq_strb, 4'b0101);
        tick();
        check("wr_c2_p_ready", p_ready, 1'b0);
        tick();
        wreq_rdy = 1'b1;
        check("wr_c3_p_ready", p_ready, 1'b0);
        check("wr_c3_wreq_vld", wreq_vld, 1'b1);
        tick();
        wreq_rdy = 1'b0;
        check("wr_c4_p_ready", p_ready, 1'b1);
        check("wr_c4_p_slverr", p_slverr, 1'b0);
        check("wr_c4_wreq_vld", wreq_vld, 1'b0);
        tick();
        apb_release();

        // ---------------- misaligned read 0x0013 ----------------
        rreq_rdy = 1'b1;
        apb_setup(16'h0013, 1'b0, 32'h0, 4'h0, 3'b000);
        check("mis_p_ready", p_ready, 1'b1);
        check("mis_p_slverr", p_slverr, 1'b1);
        check("mis_p_rdata", p_rdata, 32'h0);
        check("mis_rreq_vld", rreq_vld, 1'b0);
        tick();
        apb_release();
        check("mis_after_p_ready", p_ready, 1'b0);
        check("mis_after_rreq_vld", rreq_vld, 1'b0);

        // ---------------- out-of-window read 0x1000 ----------------
        apb_setup(16'h1000, 1'b0, 32'h0, 4'h0, 3'b000);
        check("oow_p_ready", p_ready, 1'b1);
        check("oow_p_slverr", p_slverr, 1'b1);
        check("oow_rreq_vld", rreq_vld, 1'b0);
        tick();
        apb_release();
        rreq_rdy = 1'b0;

        // ---------------- unprivileged write rejected ----------------
        wreq_rdy = 1'b1;
        apb_setup(16'h0030, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000);
        check("npriv_p_ready", p_ready, 1'b1);
        check("npriv_p_slverr", p_slverr, 1'b1);
        check("npriv_wreq_vld", wreq_vld, 1'b0);
        tick();
        apb_release();
        check("npriv_after_wreq_vld", wreq_vld, 1'b0);

        // ---------------- privileged write accepted ----------------
        apb_setup(16'h0030, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001);
        check("priv_c1_wreq_vld", wreq_vld, 1'b1);
        check("priv_c1_p_ready", p_ready, 1'b0);
        tick();
        check("priv_c2_p_ready", p_ready, 1'b1);
        check("priv_c2_p_slverr", p_slverr, 1'b0);
        tick();
        apb_release();
        wreq_rdy = 1'b0;

        // ---------------- read timeout in RACK (TIMEOUT=4) ----------------
        rreq_rdy = 1'b1;
        apb_setup(16'h0040, 1'b0, 32'h0, 4'h0, 3'b000);
        check("to_c1_rreq_vld", rreq_vld, 1'b1);
        tick();
        rreq_rdy = 1'b0;
        check("to_rack1_rack_rdy", rack_rdy, 1'b1);
        tick();
        tick();
        tick();
        check("to_rack4_rack_rdy", rack_rdy, 1'b1);
        check("to_rack4_p_ready", p_ready, 1'b0);
        tick();
        check("to_done_p_ready", p_ready, 1'b1);
        check("to_done_p_slverr", p_slverr, 1'b1);
        check("to_done_p_rdata", p_rdata, 32'h0);
        check("to_done_rack_rdy", rack_rdy, 1'b0);
        tick();
        apb_release();
        // Idle with drain pending: late response is accepted and dropped.
        check("drain_idle_rack_rdy", rack_rdy, 1'b1);
        check("drain_idle_p_ready", p_ready, 1'b0);
        rack_vld  = 1'b1;
        rack_data = 32'hAAAA_5555;
        tick();
        rack_vld = 1'b0;
        check("drained_rack_rdy", rack_rdy, 1'b0);
        check("drained_p_ready", p_ready, 1'b0);

        // Next read at the top word of the window returns its own data.
        rreq_rdy  = 1'b1;
        rack_vld  = 1'b1;
        rack_data = 32'h0000_0001;
        apb_setup(16'h0FFC, 1'b0, 32'h0, 4'h0, 3'b000);
        check("nx_c1_rreq_vld", rreq_vld, 1'b1);
        check("nx_c1_rreq_addr", rreq_addr, 16'h0FFC);
        tick();
        tick();
        check("nx_c3_p_ready", p_ready, 1'b1);
        check("nx_c3_p_rdata", p_rdata, 32'h0000_0001);
        check("nx_c3_p_slverr", p_slverr, 1'b0);
        tick();
        apb_release();
        rreq_rdy = 1'b0;
        rack_vld = 1'b0;

        // ---------------- reset during a stalled RACK ----------------
        rreq_rdy = 1'b1;
        apb_setup(16'h0050, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
        rreq_rdy = 1'b0;
        check("rr_rack_rdy", rack_rdy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rr_rack_rdy_low", rack_rdy, 1'b0);
        check("rr_rreq_addr", rreq_addr, 16'h0);
        check("rr_p_ready", p_ready, 1'b0);
        check("rr_p_slverr", p_slverr, 1'b0);
        apb_release();
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_idle_rack_rdy", rack_rdy, 1'b0);
        wreq_rdy = 1'b1;
        apb_setup(16'h0008, 1'b1, 32'hA5A5_0F0F, 4'b1111, 3'b001);
        check("rr_wr_c1_wreq_vld", wreq_vld, 1'b1);
        check("rr_wr_c1_wreq_data", wreq_data, 32'hA5A5_0F0F);
        check("rr_wr_c1_wreq_addr", wreq_addr, 16'h0008);
        tick();
        check("rr_wr_c2_p_ready", p_ready, 1'b1);
        check("rr_wr_c2_p_slverr", p_slverr, 1'b0);
        tick();
        apb_release();
        wreq_rdy = 1'b0;
        check("rr_wr_c3_p_ready", p_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regspace_bridge.md
# apb_regspace_bridge

Parametrised APB4 completer that bridges APB transfers onto the valid/ready read-request, read-acknowledge and write-request channels of a generated register space. It adds what the fixed 32-bit bridge lacks: configurable address and data widths, byte strobes passed downstream, address-window and alignment decode, a privileged-write check, a downstream timeout with PSLVERR, and recovery from late read responses. It sits between the system APB fabric and one register-space instance.

## Interface

Parameters:
- ADDR_W, 16, APB and downstream address width
- DATA_W, 32, data width; must be 8, 16, 32 or 64
- ADDR_LO, 0, lowest decoded byte address, inclusive
- ADDR_HI, 'hFFFF, highest decoded byte address, inclusive
- TIMEOUT, 16, wait-state cycles allowed per downstream handshake; 0 disables the timeout
- PRIV_WR, 0, 1 = a write with p_prot[0]=0 is rejected

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- p_addr  in  ADDR_W  APB address
- p_prot  in  3  APB protection
- p_sel, p_enable, p_write  in  1  APB control
- p_wdata  in  DATA_W  APB write data
- p_strb  in  DATA_W/8  APB byte strobes
- p_ready  out  1  APB ready
- p_rdata  out  DATA_W  APB read data
- p_slverr  out  1  APB error
- rreq_addr  out  ADDR_W  read address
- rreq_vld  out  1  read request valid
- rreq_rdy  in  1  read request ready
- rack_data  in  DATA_W  read data
- rack_vld  in  1  read data valid
- rack_rdy  out  1  read data ready
- wreq_addr  out  ADDR_W  write address
- wreq_data  out  DATA_W  write data, unmasked
- wreq_strb  out  DATA_W/8  write strobes, bit i = byte [8i+7:8i]
- wreq_vld  out  1  write request valid
- wreq_rdy  in  1  write request ready

## Operation

- FSM states: IDLE, RREQ, RACK, WREQ, DONE. All downstream outputs are Moore outputs.
- IDLE: on p_sel & !p_enable (setup phase), latch addr, write, wdata, strb and p_prot into registers. The error flag is set if any of these hold:
  - addr < ADDR_LO or addr > ADDR_HI;
  - the low log2(DATA_W/8) address bits are nonzero;
  - PRIV_WR=1 and a write arrives with p_prot[0]=0.
- IDLE next state: error → DONE; else write → WREQ; else → RREQ.
- RREQ: rreq_vld=1. On rreq_rdy, go to RACK.
- RACK: rack_rdy=1. On rack_vld, capture rack_data into the read register and go to DONE.
- WREQ: wreq_vld=1. On wreq_rdy, go to DONE.
- DONE: p_ready=1 and p_slverr=err. p_rdata = read register for a successful read, otherwise 0. Next state is always IDLE; err and the read register clear.
- Timeout (TIMEOUT>0):
  - The counter clears on entry to RREQ, RACK or WREQ and increments each cycle in those states without a handshake.
  - When count == TIMEOUT-1 and no handshake occurs in that cycle, set err and go to DONE.
  - If the handshake and the timeout occur in the same cycle, the handshake wins.
- Late-response drain:
  - A timeout in RACK sets the drain flag.
  - While drain=1, rack_rdy is also asserted in IDLE, RREQ and WREQ; the next rack_vld handshake is discarded and clears drain.
  - In RACK with drain=1, the first handshake is discarded (drain clears, state stays RACK); the second handshake is the real data.
  - A timeout in RREQ or WREQ leaves a request outstanding downstream. No drain is applied; the register space must tolerate this.
- A p_sel or p_enable deassertion mid-transfer is an APB protocol violation. It is ignored: the FSM completes the transfer and returns to IDLE.

## Timing

- Reset values: state IDLE; every valid and ready output 0; p_rdata 0; p_slverr 0; drain 0; counter 0; address and data output registers 0.
- Setup phase sampled at edge E0:
  - Zero-wait read: rreq_vld during cycle 1, rack_rdy during cycle 2, p_ready during cycle 3. The APB transfer completes at E3 with 2 wait states.
  - Zero-wait write: wreq_vld during cycle 1, p_ready during cycle 2 (1 wait state).
  - Decode error: p_ready and p_slverr during cycle 1 (0 wait states).
- Each extra downstream stall cycle adds one APB wait state.
- Maximum wait per channel is TIMEOUT cycles before the error completion.
- p_ready and p_slverr are high for exactly one cycle per transfer and never without a preceding setup phase.
- Addresses and write data stay stable from the setup edge until DONE.
- A back-to-back setup phase in the cycle after DONE is accepted.

## Test plan

- Zero-wait read at 0x0010, rack_data=0xDEADBEEF → p_ready in the third cycle after setup, p_rdata=0xDEADBEEF, p_slverr=0.
- Write to 0x0020, wdata=0x12345678, p_strb=4'b0101, with 2 cycles of wreq_rdy stall → wreq_data=0x12345678, wreq_strb=4'b0101, p_ready after 3 wait states, p_slverr=0.
- Misaligned read at 0x0013, and out-of-window read with ADDR_HI=0x0FFF at 0x1000 → p_ready and p_slverr=1 in cycle 1, p_rdata=0, no rreq_vld pulse.
- PRIV_WR=1, write with p_prot=3'b000 → slverr=1 and no wreq_vld. The same write with p_prot=3'b001 → completes with slverr=0.
- TIMEOUT=4, read with rack_vld held low → slverr=1 after 4 RACK cycles. A late rack_vld=0xAAAA5555 is then discarded, and the next read returns its own data 0x00000001.
- rst_n asserted in RACK during a stalled read → all outputs 0, state IDLE; the next write completes normally.
